duty_ctrl: RTL and testbench

DUTY_CTRL -- requirements
Module: duty_ctrl

---
 rtl/duty_ctrl.sv | 151 +++++++++++++++
 tb/tb_duty_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/duty_ctrl.sv
// duty_ctrl: soft-start / slew-limited duty controller for a half-bridge PWM.
// The compare word ramps from DUTY_MIN toward a clamped target, moving at most
// STEP counts per update tick (one tick every PRESCALE sync pulses), so duty
// changes always land on PWM period boundaries.
// Optional build macro: DUTY_CTRL_FAULT_LATCH_EN -- when defined, FAULT is
// sticky and is left only by dropping en; otherwise FAULT recovers into RAMP
// as soon as the fault input clears.
module duty_ctrl #(
  parameter int DUTY_MIN = 10,
  parameter int DUTY_MAX = 180,
  parameter int STEP     = 4,
  parameter int PRESCALE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] target,
  input  logic       sync,
  input  logic       fault,
  output logic [7:0] compare,
  output logic       pwm_en,
  output logic       ready,
  output logic       fault_flag,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_RAMP  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] MIN8     = 8'(DUTY_MIN);
  localparam logic [7:0] MAX8     = 8'(DUTY_MAX);
  localparam logic [7:0] STEP8    = 8'(STEP);
  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  state_t            st_q, st_d;
  logic [7:0]        cmp_q, cmp_d;
  logic              pwm_q, pwm_d;
  logic [7:0]        presc_q, presc_d;
  logic [7:0]        tgt_c;
  logic              tick;
  logic signed [8:0] diff;
  logic [8:0]        mag;
  logic [7:0]        slew;

  // Clamp the requested duty into the allowed switching window.
  always_comb begin
    tgt_c = target;
    if (target < MIN8)      tgt_c = MIN8;
    else if (target > MAX8) tgt_c = MAX8;
  end

  // Update tick: the PRESCALE-th sync pulse since the prescaler was cleared.
  assign tick = sync && (presc_q == PRE_LAST);

  // Slew limiter: 9-bit signed difference so the step never wraps past 0/255.
  always_comb begin
    diff = $signed({1'b0, tgt_c}) - $signed({1'b0, cmp_q});
    mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, STEP8}) slew = tgt_c;
    else if (diff[8])         slew = cmp_q - STEP8;
    else                      slew = cmp_q + STEP8;
  end

  // Next-state and next-output decode for the controller FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    st_d    = st_q;
    cmp_d   = cmp_q;
    pwm_d   = pwm_q;
    presc_d = presc_q;
    unique case (st_q)
      S_OFF: begin
        cmp_d   = 8'd0;
        pwm_d   = 1'b0;
        presc_d = 8'd0;
        if (en && !fault) begin
          st_d  = S_RAMP;
          cmp_d = MIN8;
          pwm_d = 1'b1;
        end
      end
      S_RAMP, S_RUN: begin
        if (fault) begin
          // Fault wins over en, sync and tick in the same cycle.
          st_d    = S_FAULT;
          cmp_d   = 8'd0;
          pwm_d   = 1'b0;
          presc_d = 8'd0;
        end else if (!en) begin
          st_d    = S_OFF;
          cmp_d   = 8'd0;
          pwm_d   = 1'b0;
          presc_d = 8'd0;
        end else if (sync) begin
          if (tick) begin
            presc_d = 8'd0;
            cmp_d   = slew;
            if (st_q == S_RAMP && slew == tgt_c) st_d = S_RUN;
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
      end
      S_FAULT: begin
        cmp_d   = 8'd0;
        pwm_d   = 1'b0;
        presc_d = 8'd0;
        if (!en) begin
          st_d = S_OFF;
        end
`ifdef DUTY_CTRL_FAULT_LATCH_EN
        // Sticky fault: only dropping en leaves this state.
`else
        else if (!fault) begin
          st_d  = S_RAMP;
          cmp_d = MIN8;
          pwm_d = 1'b1;
        end
`endif
      end
      default: st_d = S_OFF;
    endcase
  end

  // State and output registers; reset kills the gate enable immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= S_OFF;
      cmp_q   <= 8'd0;
      pwm_q   <= 1'b0;
      presc_q <= 8'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      st_q    <= st_d;
      cmp_q   <= cmp_d;
      pwm_q   <= pwm_d;
      presc_q <= presc_d;
    end
  end

  assign compare    = cmp_q;
  assign pwm_en     = pwm_q;
  assign ready      = (st_q == S_RUN);
  assign fault_flag = (st_q == S_FAULT);
  assign state      = st_q;

endmodule

// File: tb/tb_duty_ctrl.sv
// Self-checking bench for duty_ctrl (default parameters). Expected values are
// queued when stimulus is driven and compared one edge later.
module tb_duty_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] target;
  logic       sync;
  logic       fault;
  logic [7:0] compare;
  logic       pwm_en;
  logic       ready;
  logic       fault_flag;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] cmp;
    logic       pwm;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic [7:0] tgt;
    logic       s;
    logic       f;
    logic [1:0] xs;
    logic [7:0] xc;
    logic       xp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[18];

  duty_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .target     (target),
    .sync       (sync),
    .fault      (fault),
    .compare    (compare),
    .pwm_en     (pwm_en),
    .ready      (ready),
    .fault_flag (fault_flag),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare all outputs against the oldest queued expectation.
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, " state"},      32'(state),      32'(e.st));
    check({tag, " compare"},    32'(compare),    32'(e.cmp));
    check({tag, " pwm_en"},     32'(pwm_en),     32'(e.pwm));
    check({tag, " ready"},      32'(ready),      32'(e.st == 2'd2));
    check({tag, " fault_flag"}, 32'(fault_flag), 32'(e.st == 2'd3));
  endtask

  // Drive one cycle of inputs at the falling edge, check after the rising edge.
  task automatic step(input string tag, input logic e, input logic [7:0] t, input logic s,
                      input logic f, input logic [1:0] xs, input logic [7:0] xc, input logic xp);
    @(negedge clk);
    en = e; target = t; sync = s; fault = f;
    sb.push_back('{xs, xc, xp});
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sync = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] xc;
    // Table: starts in RUN at compare=10 with the prescaler cleared.
    vecs[0]  = '{1'b0, 8'd10,  1'b0, 1'b0, 2'd0, 8'd0,  1'b0};
    vecs[1]  = '{1'b1, 8'd18,  1'b0, 1'b1, 2'd0, 8'd0,  1'b0};
    vecs[2]  = '{1'b1, 8'd18,  1'b0, 1'b0, 2'd1, 8'd10, 1'b1};
    vecs[3]  = '{1'b1, 8'd18,  1'b1, 1'b0, 2'd1, 8'd10, 1'b1};
    vecs[4]  = '{1'b1, 8'd200, 1'b1, 1'b0, 2'd1, 8'd14, 1'b1};
    vecs[5]  = '{1'b1, 8'd18,  1'b1, 1'b0, 2'd1, 8'd14, 1'b1};
    vecs[6]  = '{1'b1, 8'd60,  1'b0, 1'b0, 2'd1, 8'd14, 1'b1};
    vecs[7]  = '{1'b1, 8'd30,  1'b1, 1'b0, 2'd1, 8'd18, 1'b1};
    vecs[8]  = '{1'b1, 8'd30,  1'b1, 1'b0, 2'd1, 8'd18, 1'b1};
    vecs[9]  = '{1'b1, 8'd30,  1'b1, 1'b1, 2'd3, 8'd0,  1'b0};
    vecs[10] = '{1'b1, 8'd30,  1'b0, 1'b1, 2'd3, 8'd0,  1'b0};
`ifdef DUTY_CTRL_FAULT_LATCH_EN
    vecs[11] = '{1'b1, 8'd30,  1'b0, 1'b0, 2'd3, 8'd0,  1'b0};
    vecs[12] = '{1'b0, 8'd30,  1'b0, 1'b0, 2'd0, 8'd0,  1'b0};
    vecs[13] = '{1'b1, 8'd30,  1'b0, 1'b0, 2'd1, 8'd10, 1'b1};
`else
    vecs[11] = '{1'b1, 8'd30,  1'b0, 1'b0, 2'd1, 8'd10, 1'b1};
    vecs[12] = '{1'b1, 8'd30,  1'b1, 1'b0, 2'd1, 8'd10, 1'b1};
    vecs[13] = '{1'b0, 8'd30,  1'b0, 1'b0, 2'd0, 8'd0,  1'b0};
`endif
    vecs[14] = '{1'b0, 8'd30,  1'b0, 1'b0, 2'd0, 8'd0,  1'b0};
    vecs[15] = '{1'b1, 8'd30,  1'b0, 1'b0, 2'd1, 8'd10, 1'b1};
    vecs[16] = '{1'b0, 8'd30,  1'b0, 1'b1, 2'd3, 8'd0,  1'b0};
    vecs[17] = '{1'b0, 8'd30,  1'b0, 1'b0, 2'd0, 8'd0,  1'b0};

    en = 1'b0; target = 8'd0; sync = 1'b0; fault = 1'b0;

    // Asynchronous reset before any clock edge.
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    sb.push_back('{2'd0, 8'd0, 1'b0});
    pop_check("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Soft start to 30 with a sync pulse every 201 clocks.
    step("start", 1'b1, 8'd30, 1'b0, 1'b0, 2'd1, 8'd10, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      idle(200);
      step($sformatf("ramp30 sync%0d", k), 1'b1, 8'd30, 1'b1, 1'b0,
           (k == 10) ? 2'd2 : 2'd1, 8'(10 + 4 * (k / 2)), 1'b1);
    end

    // Large step up: climbs by 4 per tick, clamped at 180.
    xc = 8'd30;
    for (int t = 0; t < 50; t++) begin
      step("up hold", 1'b1, 8'd250, 1'b1, 1'b0, 2'd2, xc, 1'b1);
      xc = (8'd180 - xc <= 8'd4) ? 8'd180 : xc + 8'd4;
      step($sformatf("up tick%0d", t), 1'b1, 8'd250, 1'b1, 1'b0, 2'd2, xc, 1'b1);
    end

    // Step down to 0: descends by 4 per tick, floor at 10.
    for (int t = 0; t < 50; t++) begin
      step("down hold", 1'b1, 8'd0, 1'b1, 1'b0, 2'd2, xc, 1'b1);
      xc = (xc - 8'd10 <= 8'd4) ? 8'd10 : xc - 8'd4;
      step($sformatf("down tick%0d", t), 1'b1, 8'd0, 1'b1, 1'b0, 2'd2, xc, 1'b1);
    end

    // Table vectors: enable/disable, clamp, between-tick target, fault paths.
    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), vecs[i].en, vecs[i].tgt, vecs[i].s, vecs[i].f,
           vecs[i].xs, vecs[i].xc, vecs[i].xp);
    end

    // Bring up to RUN at 100, then reset between clock edges.
    step("run100 start", 1'b1, 8'd100, 1'b0, 1'b0, 2'd1, 8'd10, 1'b1);
    for (int i = 0; i < 80 && state != 2'd2; i++) begin
      @(negedge clk);
      sync = 1'b1;
      @(posedge clk);
      #1;
    end
    sb.push_back('{2'd2, 8'd100, 1'b1});
    pop_check("run100");
    @(negedge clk);
    sync = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    sb.push_back('{2'd0, 8'd0, 1'b0});
    pop_check("async reset");
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{2'd1, 8'd10, 1'b1});
    @(posedge clk);
    #1;
    pop_check("restart after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
